// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serial scan controller with overlapping pattern detect.
// Words are shifted out MSB-first; the detect window persists across word boundaries.
module seq_scan_ctrl #(
  parameter int                WORD_W  = 8,
  parameter int                PAT_W   = 3,
  parameter int                CNT_W   = 8,
  parameter logic [PAT_W-1:0]  PAT_RST = 3'b101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              clr,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done,
  output logic [1:0]        state_out
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    REPORT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_W-1:0]   window, pattern, win_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic               accept, shifting, hit;

  assign accept   = (state == IDLE) && s_valid;
  assign shifting = (state == SHIFT);

  // Window/fill as they will be after the current bit is absorbed
  assign win_nxt  = {window[PAT_W-2:0], shreg[WORD_W-1]};
  assign fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
  assign hit      = (win_nxt == pattern) && (fill_nxt == FILL_W'(PAT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_idx == '0) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state == IDLE);
    bit_valid = (state == SHIFT);
    done      = (state == REPORT);
    bit_out   = shreg[WORD_W-1];
    state_out = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      shreg   <= s_data;
      bit_idx <= IDX_W'(WORD_W - 1);
    end else if (shifting) begin
      shreg   <= shreg << 1;
      bit_idx <= bit_idx - IDX_W'(1);
    end
  end

  // Detection datapath; clr wins over both the window update and the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window    <= '0;
      fill      <= '0;
      pattern   <= PAT_RST;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (state == IDLE && cfg_we) pattern <= cfg_pattern;
      if (clr) begin
        window    <= '0;
        fill      <= '0;
        match     <= 1'b0;
        match_cnt <= '0;
      end else if (shifting) begin
        window <= win_nxt;
        fill   <= fill_nxt;
        match  <= hit;
        if (hit && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
      end else begin
        match <= 1'b0;
        if (state == IDLE && cfg_we) begin
          window <= '0;
          fill   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - randomized and directed bench for seq_scan_ctrl.
// Reference model keeps the received-bit history as a queue and matches its tail.
module tb_seq_scan_ctrl;
  localparam int WORD_W = 8;
  localparam int PAT_W  = 3;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              clr;
  logic              bit_out;
  logic              bit_valid;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic              done;
  logic [1:0]        state_out;

  int vecs = 0;
  int errs = 0;

  bit             hist[$];
  logic [PAT_W-1:0] mpat;
  int             mcnt;
  bit             mmatch;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RST(3'b101)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .clr(clr), .bit_out(bit_out),
    .bit_valid(bit_valid), .match(match), .match_cnt(match_cnt), .done(done),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit();
    if (hist.size() < PAT_W) return 1'b0;
    for (int j = 0; j < PAT_W; j++)
      if (hist[hist.size() - PAT_W + j] != mpat[PAT_W-1-j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset_window();
    hist.delete();
  endfunction

  function automatic void model_consume(input bit b, input bit c);
    if (c) begin
      hist.delete();
      mcnt   = 0;
      mmatch = 1'b0;
    end else begin
      hist.push_back(b);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      mmatch = model_hit();
      if (mmatch && mcnt < CNT_MAX) mcnt++;
    end
  endfunction

  task automatic send_word(input logic [WORD_W-1:0] d, input int clr_at, input int cfg_at,
                           input logic [PAT_W-1:0] cfg_val);
    vecs++;
    if (s_ready !== 1'b1) begin
      errs++; $display("FAIL accept_ready: got %b want 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
    s_data  = WORD_W'($urandom);
    for (int i = 0; i < WORD_W; i++) begin
      vecs++;
      if (bit_valid !== 1'b1 || done !== 1'b0 || bit_out !== d[WORD_W-1-i] ||
          match !== mmatch || match_cnt !== CNT_W'(mcnt)) begin
        errs++;
        $display("FAIL shift_bit%0d: bv=%b done=%b bit=%b match=%b cnt=%0d want bv=1 done=0 bit=%b match=%b cnt=%0d",
                 i, bit_valid, done, bit_out, match, match_cnt, d[WORD_W-1-i], mmatch, mcnt);
      end
      clr         = (i == clr_at);
      cfg_we      = (i == cfg_at);
      cfg_pattern = cfg_val;
      model_consume(d[WORD_W-1-i], i == clr_at);
      tick();
      clr    = 1'b0;
      cfg_we = 1'b0;
    end
    vecs++;
    if (done !== 1'b1 || state_out !== 2'b10 || match !== mmatch || match_cnt !== CNT_W'(mcnt)) begin
      errs++;
      $display("FAIL report: done=%b st=%b match=%b cnt=%0d want done=1 st=10 match=%b cnt=%0d",
               done, state_out, match, match_cnt, mmatch, mcnt);
    end
    mmatch = 1'b0;
    tick();
    vecs++;
    if (s_ready !== 1'b1 || state_out !== 2'b00 || match !== 1'b0 || match_cnt !== CNT_W'(mcnt)) begin
      errs++;
      $display("FAIL back_idle: rdy=%b st=%b match=%b cnt=%0d want rdy=1 st=00 match=0 cnt=%0d",
               s_ready, state_out, match, match_cnt, mcnt);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_reset_window();
    mcnt = 0;
    mmatch = 1'b0;
    vecs++;
    if (match_cnt !== '0 || state_out !== 2'b00) begin
      errs++; $display("FAIL idle_clr: cnt=%0d st=%b want cnt=0 st=00", match_cnt, state_out);
    end
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p);
    cfg_we = 1'b1;
    cfg_pattern = p;
    tick();
    cfg_we = 1'b0;
    mpat = p;
    model_reset_window();
    vecs++;
    if (state_out !== 2'b00 || match_cnt !== CNT_W'(mcnt)) begin
      errs++; $display("FAIL cfg_idle: st=%b cnt=%0d want st=00 cnt=%0d", state_out, match_cnt, mcnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (s_ready !== 1'b1 || bit_valid !== 1'b0 || bit_out !== 1'b0 || match !== 1'b0 ||
          match_cnt !== '0 || done !== 1'b0 || state_out !== 2'b00) begin
        errs++;
        $display("FAIL reset_hold: rdy=%b bv=%b bit=%b m=%b cnt=%0d done=%b st=%b want 1 0 0 0 0 0 00",
                 s_ready, bit_valid, bit_out, match, match_cnt, done, state_out);
      end
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    mpat = 3'b101; mcnt = 0; mmatch = 1'b0; model_reset_window();
  endtask

  task automatic test_basic();
    send_word(8'b10101100, -1, -1, '0);
    vecs++;
    if (match_cnt !== 8'd2) begin
      errs++; $display("FAIL basic_count: got %0d want 2", match_cnt);
    end
  endtask

  task automatic test_cross_word();
    do_clr();
    send_word(8'b00000010, -1, -1, '0);
    send_word(8'b10000000, -1, -1, '0);
    vecs++;
    if (match_cnt !== 8'd1) begin
      errs++; $display("FAIL cross_word: got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_config();
    do_cfg(3'b111);
    do_clr();
    send_word(8'hFF, -1, -1, '0);
    vecs++;
    if (match_cnt !== 8'd6) begin
      errs++; $display("FAIL cfg_111: got %0d want 6", match_cnt);
    end
    send_word(8'hFF, -1, 2, 3'b000);
    vecs++;
    if (match_cnt !== 8'd14) begin
      errs++; $display("FAIL cfg_ignored: got %0d want 14", match_cnt);
    end
  endtask

  task automatic test_clr_shift();
    do_clr();
    send_word(8'hFF, 4, -1, '0);
    vecs++;
    if (match_cnt !== 8'd1) begin
      errs++; $display("FAIL clr_shift: got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_saturate();
    do_clr();
    for (int w = 0; w < 34; w++) send_word(8'hFF, -1, -1, '0);
    vecs++;
    if (match_cnt !== 8'd255) begin
      errs++; $display("FAIL saturate: got %0d want 255", match_cnt);
    end
  endtask

  task automatic test_async_reset();
    s_valid = 1'b1;
    s_data  = 8'hC3;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (state_out !== 2'b00 || bit_valid !== 1'b0 || match_cnt !== '0 || s_ready !== 1'b1 ||
        bit_out !== 1'b0 || match !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: st=%b bv=%b cnt=%0d rdy=%b bit=%b m=%b want 00 0 0 1 0 0",
               state_out, bit_valid, match_cnt, s_ready, bit_out, match);
    end
    #2 rst = 1'b1;
    tick();
    mpat = 3'b101; mcnt = 0; mmatch = 1'b0; model_reset_window();
    send_word(8'b10100000, -1, -1, '0);
    vecs++;
    if (match_cnt !== 8'd1) begin
      errs++; $display("FAIL reset_pattern: got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) do_cfg(PAT_W'($urandom_range(0, 7)));
      if ($urandom_range(0, 4) == 0) do_clr();
      send_word(WORD_W'($urandom), int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                PAT_W'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    s_valid = 1'b0; s_data = '0; cfg_we = 1'b0; cfg_pattern = '0; clr = 1'b0;
    test_reset();
    test_basic();
    test_cross_word();
    test_config();
    test_clr_shift();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Serial-scan controller for the pattern-detect path. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Runs overlapping detection of a programmable PAT_W-bit pattern across word boundaries and counts matches.
- Reports completion of each word to the host sequencer.

Parameters:
- WORD_W, 8, width of each input word / bits serialised per transaction
- PAT_W, 3, pattern length in bits (>=2)
- CNT_W, 8, match counter width
- PAT_RST, 3'b101, pattern value loaded at reset (width PAT_W)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- s_valid  input  1  input word valid
- s_ready  output  1  controller can accept a word
- s_data  input  WORD_W  word to serialise, MSB sent first
- cfg_we  input  1  pattern write strobe, honoured only in IDLE
- cfg_pattern  input  PAT_W  new pattern, first-received bit in MSB
- clr  input  1  synchronous clear of history window, fill count, match_cnt, match
- bit_out  output  1  current serial bit = shreg MSB
- bit_valid  output  1  high while bit_out is a live scan bit
- match  output  1  registered 1-cycle pulse per detected pattern
- match_cnt  output  CNT_W  saturating total match count
- done  output  1  1-cycle pulse after the last bit of a word
- state_out  output  2  current FSM state

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, window=0, fill=0, bit_idx=0, pattern=PAT_RST, match=0, match_cnt=0. Resulting outputs: s_ready=1, bit_valid=0, bit_out=0, done=0, state_out=2'b00.
- States: IDLE=2'b00, SHIFT=2'b01, REPORT=2'b10. Code 2'b11 is illegal and returns to IDLE next clock with no other side effects.
- Combinational outputs: s_ready=(state==IDLE), bit_valid=(state==SHIFT), bit_out=shreg[WORD_W-1], done=(state==REPORT), state_out=state.
- IDLE:
  - s_valid&&s_ready: shreg<=s_data, bit_idx<=WORD_W-1, ->SHIFT.
  - cfg_we: pattern<=cfg_pattern, window<=0, fill<=0. May coincide with word acceptance.
- SHIFT, each clock:
  - window<={window[PAT_W-2:0],bit_out}; fill<=min(fill+1,PAT_W); shreg<=shreg<<1.
  - bit_idx decrements. When bit_idx==0 -> REPORT.
- Detection: match<=1 when the updated window==pattern and the updated fill==PAT_W; otherwise match<=0. Detection is overlapping.
  - match_cnt increments in the same cycle that match is set; it holds at all-ones (saturates).
  - match appears in the cycle after the bit that completes the pattern. The match for the last bit of a word coincides with done.
- REPORT: lasts one cycle, then ->IDLE. match_cnt is final for the word during this cycle.
- Timing: word accepted at edge k. Bits are live in cycles k+1..k+WORD_W, done in k+WORD_W+1, s_ready in k+WORD_W+2. Throughput is one word per WORD_W+2 cycles.
- Window and fill persist across words: patterns may span a word boundary.
- cfg_we outside IDLE is ignored; the pattern never changes mid-word.
- clr, any state:
  - Clears window, fill, match, match_cnt. Takes priority over the increment and window update.
  - In SHIFT the current bit is still consumed (bit_idx/shreg advance) but is not entered into the window.
  - Does not change FSM state.
- match is forced to 0 in any cycle where the state is IDLE and no bit was consumed on the prior edge.
- Async reset mid-SHIFT: outputs go to reset values immediately and the partial word is discarded.

Test Plan:
- Reset: hold rst=0, drive s_valid=1 -> s_ready=1, bit_valid=0, match_cnt=0, state_out=00; no word accepted until rst=1.
- Pattern 101, word 8'b10101100 -> bit_out sequence 1,0,1,0,1,1,0,0; match pulses in cycles k+4 and k+6; done at k+9 with match_cnt=2; s_ready=1 at k+10.
- Cross-word: 8'b00000010 then 8'b10000000 -> no match in word 1; match in the cycle after the first bit of word 2; match_cnt=1.
- Config: cfg_we with 3'b111 in IDLE, then word 8'hFF -> 6 matches, match_cnt=6. A cfg_we pulse of 3'b000 during SHIFT is ignored; pattern stays 111.
- clr in SHIFT after 4 bits of 8'hFF (pattern 111) -> match_cnt=0 next cycle; remaining 3 bits yield 1 match. Back-to-back 8'hFF words with CNT_W=8 -> match_cnt saturates at 255, no wrap.
- Async reset in the 3rd SHIFT cycle -> state_out=00, bit_valid=0, match_cnt=0, pattern back to 101 without a clock edge.
